serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial multi-bit adder: sums two WIDTH-bit operands one bit per clock, LSB first, with one carry flip-flop.
- Per-bit arithmetic is a full-adder cell built from two half-adder stages; this block is the sequential stage that drives that half-adder datapath and consumes its sum and carry.
- Used as the low-area alternative to a combinational ripple adder.
- Start/done handshake to the surrounding control logic.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  high while an addition is in progress (RUN state).
- done  output  1  single-cycle pulse; high when the result has just become valid.
- sum  output  WIDTH  registered result; holds the last completed sum.
- c_out  output  1  registered carry out of the MSB; holds with sum.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, sum=0, c_out=0, internal shift registers, carry and counter cleared. Reset takes effect mid-operation: the addition in flight is abandoned and no done pulse is issued.
- States: IDLE, RUN, DONE. Encoding comes from the package.
- IDLE:
  - start=1 at edge E0: latch a and b into shift registers sa and sb; clear the carry flop and the bit counter; go to RUN.
  - busy goes high after E0.
  - start=0: remain in IDLE.
- RUN, edges E1..E_WIDTH, one bit per edge:
  - s = sa[0]^sb[0]^carry.
  - carry_next = majority(sa[0], sb[0], carry).
  - Shift sa and sb right by one.
  - Shift s into the MSB of an internal result shift register.
  - Increment the counter.
- RUN exit at edge E_WIDTH (counter reaches WIDTH-1 before that edge):
  - Load the sum output from the completed shift register, including the final bit.
  - Load c_out with the final carry.
  - Go to DONE: done=1, busy=0.
- DONE: at edge E_WIDTH+1, go to IDLE and set done=0. done is high for exactly one cycle.
- Latency: result valid and done high WIDTH edges after the accepting edge E0.
- start is ignored in RUN and DONE and is not queued. A start held high through DONE is accepted at the first IDLE edge.
- Back-to-back throughput: one addition per WIDTH+2 cycles.
- sum and c_out change only at completion. Intermediate shifting is never visible on the outputs. Values hold until the next completion or reset.
- a and b may change freely after the accepting edge.
- Counter width: $clog2(WIDTH); the counter does not wrap within a legal operation.
- Arithmetic is unsigned, modulo 2^WIDTH, with overflow reported on c_out.
- No X propagation from start or operands in IDLE beyond capture.

Decomposition:
- Shared package/include: state localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
- One sub-module: full_adder_bit. It is the combinational 1-bit full adder (two half-adder stages plus OR for carry), instantiated once and fed by sa[0], sb[0] and carry.
- FSM, counter and shift registers stay in serial_adder.

Test Plan (WIDTH=8):
- Addition cases, each with start pulsed for one cycle:
  - a=0x00, b=0x00 -> done pulse exactly 8 edges after accept; sum=0x00, c_out=0.
  - a=0xFF, b=0x01 -> sum=0x00, c_out=1; busy high for 8 cycles, then done high for 1 cycle.
  - a=0xA5, b=0x5A -> sum=0xFF, c_out=0.
  - a=0x80, b=0x80 -> sum=0x00, c_out=1.
- Start while busy: accept a=0x0F, b=0x01, pulse start=1 with a=0xFF, b=0xFF at cycle 3 of RUN -> result sum=0x10, c_out=0; only one done pulse. Start held high through DONE -> new addition accepted on the first IDLE edge.
- Reset mid-operation: accept 0x33+0x44, drive rst_n=0 asynchronously at RUN cycle 4 -> busy=0, done=0, sum=0x00, c_out=0 immediately; no done pulse follows. After release, 0x33+0x44 -> sum=0x77, c_out=0.
- Exhaustive sweep at WIDTH=4: all 256 a/b pairs -> {c_out,sum} equals a+b for every pair; sum holds steady between completions.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Purpose : shared constants and FSM state encoding for the bit-serial adder.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Purpose : start/done handshake plus operand and result bus for serial_adder.
// Latency : n/a (wiring only).
// Backpressure: none; start is only honoured while the adder is idle.
//
// Signals: start, a, b   requester -> adder
//          busy, done, sum, c_out   adder -> requester
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    modport master (
        output start, a, b,
        input  busy, done, sum, c_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, sum, c_out
    );

endinterface

// File: rtl/serial_adder_full_adder_bit.sv
// Purpose : combinational 1-bit full adder built from two half-adder stages.
// Latency : 0 cycles (pure combinational).
// Backpressure: n/a.
//
// Ports: a_i, b_i, c_i operand bits and carry in; s_o sum bit; c_o carry out.
module full_adder_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    logic p1;   // first half adder: propagate
    logic g1;   // first half adder: generate
    logic g2;   // second half adder: carry from propagate + carry-in

    assign p1  = a_i ^ b_i;
    assign g1  = a_i & b_i;
    assign s_o = p1 ^ c_i;
    assign g2  = p1 & c_i;
    assign c_o = g1 | g2;

endmodule

// File: rtl/serial_adder.sv
// Purpose : bit-serial WIDTH-bit unsigned adder, LSB first, one carry flop.
// Latency : done and result WIDTH edges after the accepting edge; WIDTH+2 cycles per add.
// Backpressure: start is ignored (not queued) while busy or done is high.
//
// Ports: clk, rst_n (async active-low); bus (slave) carries start/a/b in and
//        busy/done/sum/c_out out. sum and c_out change only at completion.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               c_out_q, c_out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               fa_s;
    logic               fa_c;
    logic [WIDTH-1:0]   res_shift;

    full_adder_bit u_fa (
        .a_i (sa_q[0]),
        .b_i (sb_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 holds the LSB.
    assign res_shift = {fa_s, res_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    res_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sa_d    = {1'b0, sa_q[WIDTH-1:1]};
                sb_d    = {1'b0, sb_q[WIDTH-1:1]};
                res_d   = res_shift;
                carry_d = fa_c;
                cnt_d   = cnt_q + CNT_W'(1);
                // Last bit: publish straight from the shift value so the final
                // bit is included without an extra cycle.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    sum_d   = res_shift;
                    c_out_d = fa_c;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy  = (state_q == RUN);
    assign bus.done  = (state_q == DONE);
    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;

endmodule
